// File: rtl/aes_pkg.sv
// Shared constants for the AES Wishbone register front-end: register map,
// CTRL/STATUS bit positions, KEY command bits and the sequencer states.
package aes_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;

  // Byte offsets within the decoded window
  localparam int unsigned A_CTRL = 'h00;
  localparam int unsigned A_ENC  = 'h04;
  localparam int unsigned A_DEC  = 'h08;
  localparam int unsigned A_KEY  = 'h0C;
  localparam int unsigned A_DIN  = 'h10;
  localparam int unsigned A_IV   = 'h20;
  localparam int unsigned A_RES0 = 'h30;
  localparam int unsigned A_RES1 = 'h34;
  localparam int unsigned A_RES2 = 'h38;
  localparam int unsigned A_RES3 = 'h3C;
  localparam int unsigned A_KEYP = 'h40;

  localparam int CTRL_KEYRDY = 0;
  localparam int CTRL_IDLE   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_CBC    = 3;
  localparam int CTRL_AES256 = 4;

  localparam int KCMD_EXPAND = 0;
  localparam int KCMD_HI     = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYGEN = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/aes_wb_pushreg.sv
// 128-bit register filled one 32-bit word at a time; the oldest word falls
// off the top. A parallel load (used for CBC chaining) takes priority.
module aes_wb_pushreg
  import aes_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_dat,
  input  logic              i_load,
  input  logic [BLK_W-1:0]  i_load_dat,
  output logic [BLK_W-1:0]  o_q
);

  logic [BLK_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_q <= '0;
    else if (i_load) r_q <= i_load_dat;
    else if (i_push) r_q <= {r_q[BLK_W-WORD_W-1:0], i_dat};
  end

  assign o_q = r_q;

endmodule

// File: rtl/aes_wb_regs.sv
// Wishbone classic slave front-end for the AES core: register decode, key/IV/
// data loading, command pulses, CBC chaining and a small op sequencer.
module aes_wb_regs
  import aes_pkg::*;
#(
  parameter int ADDR_BITS = 8
)(
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         wbs_stb_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic [31:0]  wbs_dat_o,
  output logic         wbs_ack_o,
  output logic         aes256_o,
  output logic [255:0] key_o,
  output logic         key_expand_o,
  input  logic         key_done_i,
  output logic [127:0] blk_o,
  output logic         enc_start_o,
  output logic         dec_start_o,
  input  logic [127:0] blk_i,
  input  logic         blk_valid_i
);

  state_e r_state, w_state_nx;

  logic         r_ack;
  logic [31:0]  r_dat;
  logic         r_cbc, r_aes256, r_done, r_key_rdy, r_dec;
  logic         r_enc_start, r_dec_start, r_key_expand;
  logic [127:0] r_key_hi, r_blk, r_result;

  logic [127:0] w_din, w_iv, w_key_lo, w_iv_nx;
  logic [31:0]  w_rd_dat;
  logic [ADDR_BITS-1:0] w_off;
  logic w_acc, w_wr, w_idle, w_wr_ok;
  logic w_sel_ctrl, w_sel_enc, w_sel_dec, w_sel_key, w_sel_din, w_sel_iv, w_sel_keyp;
  logic w_start_enc, w_start_dec, w_key_exp, w_key_hi, w_keyed, w_finish, w_iv_load;
  logic w_unused;

  assign w_unused = ^{wbs_adr_i[31:ADDR_BITS], wbs_adr_i[1:0]};

  assign w_off  = {wbs_adr_i[ADDR_BITS-1:2], 2'b00};
  assign w_acc  = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr   = w_acc & wbs_we_i & (wbs_sel_i == 4'hF);
  assign w_idle = (r_state == ST_IDLE);
  // Any state-changing write is dropped while an operation is in flight
  assign w_wr_ok = w_wr & w_idle;

  assign w_sel_ctrl = (w_off == ADDR_BITS'(A_CTRL));
  assign w_sel_enc  = (w_off == ADDR_BITS'(A_ENC));
  assign w_sel_dec  = (w_off == ADDR_BITS'(A_DEC));
  assign w_sel_key  = (w_off == ADDR_BITS'(A_KEY));
  assign w_sel_din  = (w_off == ADDR_BITS'(A_DIN));
  assign w_sel_iv   = (w_off == ADDR_BITS'(A_IV));
  assign w_sel_keyp = (w_off == ADDR_BITS'(A_KEYP));

  assign w_start_enc = w_wr_ok & w_sel_enc & wbs_dat_i[0] & r_key_rdy;
  assign w_start_dec = w_wr_ok & w_sel_dec & wbs_dat_i[0] & r_key_rdy;
  assign w_key_exp   = w_wr_ok & w_sel_key & wbs_dat_i[KCMD_EXPAND];
  assign w_key_hi    = w_wr_ok & w_sel_key & wbs_dat_i[KCMD_HI];
  assign w_keyed     = (r_state == ST_KEYGEN) & key_done_i;
  assign w_finish    = (r_state == ST_RUN) & blk_valid_i;

  // CBC: encrypt chains on the ciphertext out, decrypt on the ciphertext in
  assign w_iv_load = w_finish & r_cbc;
  assign w_iv_nx   = r_dec ? w_din : blk_i;

  aes_wb_pushreg u_din (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_push(w_wr_ok & w_sel_din),
    .i_dat(wbs_dat_i), .i_load(1'b0), .i_load_dat('0), .o_q(w_din)
  );

  aes_wb_pushreg u_iv (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_push(w_wr_ok & w_sel_iv),
    .i_dat(wbs_dat_i), .i_load(w_iv_load), .i_load_dat(w_iv_nx), .o_q(w_iv)
  );

  aes_wb_pushreg u_key (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_push(w_wr_ok & w_sel_keyp),
    .i_dat(wbs_dat_i), .i_load(1'b0), .i_load_dat('0), .o_q(w_key_lo)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_enc || w_start_dec) w_state_nx = ST_RUN;
        else if (w_key_exp)             w_state_nx = ST_KEYGEN;
      end
      ST_KEYGEN: if (key_done_i)  w_state_nx = ST_IDLE;
      ST_RUN:    if (blk_valid_i) w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_rd_dat = '0;
    case (w_off)
      ADDR_BITS'(A_CTRL): w_rd_dat = {27'b0, r_aes256, r_cbc, r_done, w_idle, r_key_rdy};
      ADDR_BITS'(A_RES0): w_rd_dat = r_result[127:96];
      ADDR_BITS'(A_RES1): w_rd_dat = r_result[95:64];
      ADDR_BITS'(A_RES2): w_rd_dat = r_result[63:32];
      ADDR_BITS'(A_RES3): w_rd_dat = r_result[31:0];
      default:            w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_cbc        <= 1'b0;
      r_aes256     <= 1'b0;
      r_done       <= 1'b0;
      r_key_rdy    <= 1'b0;
      r_dec        <= 1'b0;
      r_enc_start  <= 1'b0;
      r_dec_start  <= 1'b0;
      r_key_expand <= 1'b0;
      r_key_hi     <= '0;
      r_blk        <= '0;
      r_result     <= '0;
    end else begin
      r_ack        <= w_acc;
      r_dat        <= (w_acc && !wbs_we_i) ? w_rd_dat : '0;
      r_enc_start  <= w_start_enc;
      r_dec_start  <= w_start_dec;
      r_key_expand <= w_key_exp;
      if (w_wr_ok && w_sel_ctrl) begin
        r_cbc    <= wbs_dat_i[CTRL_CBC];
        r_aes256 <= wbs_dat_i[CTRL_AES256];
      end
      if (w_key_hi) r_key_hi <= w_key_lo;
      if (w_key_exp)    r_key_rdy <= 1'b0;
      else if (w_keyed) r_key_rdy <= 1'b1;
      // Input block is frozen here so later pushes cannot disturb the core
      if (w_start_enc || w_start_dec) begin
        r_done <= 1'b0;
        r_dec  <= w_start_dec;
        r_blk  <= (r_cbc && w_start_enc) ? (w_din ^ w_iv) : w_din;
      end
      if (w_finish) begin
        r_done   <= 1'b1;
        r_result <= (r_cbc && r_dec) ? (blk_i ^ w_iv) : blk_i;
      end
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign aes256_o     = r_aes256;
  assign key_o        = {r_key_hi, w_key_lo};
  assign key_expand_o = r_key_expand;
  assign blk_o        = r_blk;
  assign enc_start_o  = r_enc_start;
  assign dec_start_o  = r_dec_start;

endmodule

// File: tb/tb_aes_wb_regs.sv
// Directed bench for aes_wb_regs: Wishbone master tasks plus a known-answer
// AES core model (FIPS-197 vector, identity otherwise, configurable latency).
module tb_aes_wb_regs;

  localparam logic [7:0] R_CTRL = 8'h00, R_ENC = 8'h04, R_DEC = 8'h08, R_KEY = 8'h0C;
  localparam logic [7:0] R_DIN = 8'h10, R_IV = 8'h20, R_RES = 8'h30, R_KEYP = 8'h40;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = '0, dat_i = '0, dat_o;
  logic ack, aes256, key_expand, enc_start, dec_start;
  logic [255:0] key;
  logic key_done = 1'b0, blk_valid = 1'b0;
  logic [127:0] blk_o, blk_i = '0;

  int n_chk = 0, n_fail = 0;
  int core_lat = 3;
  int n_enc = 0;

  always #5 clk = ~clk;

  aes_wb_regs #(.ADDR_BITS(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .aes256_o(aes256), .key_o(key),
    .key_expand_o(key_expand), .key_done_i(key_done), .blk_o(blk_o),
    .enc_start_o(enc_start), .dec_start_o(dec_start), .blk_i(blk_i),
    .blk_valid_i(blk_valid)
  );

  function automatic logic [127:0] core_fn(bit dec, logic [127:0] k, logic [127:0] b);
    if (k == FK && !dec && b == PT) return CT;
    if (k == FK && dec && b == CT) return PT;
    return b;
  endfunction

  // Core model, reset by the same pin as the DUT
  bit c_dec, c_key;
  int c_cnt;
  logic [127:0] c_in;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt <= 0; c_dec <= 0; c_key <= 0; c_in <= '0;
      key_done <= 0; blk_valid <= 0; blk_i <= '0;
    end else begin
      key_done  <= 0;
      blk_valid <= 0;
      if (enc_start || dec_start) begin
        c_cnt <= core_lat; c_dec <= dec_start; c_key <= 0; c_in <= blk_o;
      end else if (key_expand) begin
        c_cnt <= core_lat; c_key <= 1;
      end else if (c_cnt > 0) begin
        c_cnt <= c_cnt - 1;
        if (c_cnt == 1) begin
          if (c_key) key_done <= 1;
          else begin
            blk_valid <= 1;
            blk_i     <= core_fn(c_dec, key[127:0], c_in);
          end
        end
      end
    end
  end

  always @(posedge clk) if (enc_start === 1'b1) n_enc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb(input bit w, input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = 32'h3000_0000 | {24'h0, a}; dat_i = d; sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 4);
    chk("ack_latency", 128'(n), 128'(1));
    rd = dat_o;
    @(negedge clk);
    stb = 0; cyc = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_single", 128'(ack), 128'(0));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] x;
    wb(1, a, d, 4'hF, x);
  endtask

  task automatic rdchk(input string nm, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] x;
    wb(0, a, 32'h0, 4'hF, x);
    chk(nm, 128'(x), 128'(e));
  endtask

  task automatic push4(input logic [7:0] a, input logic [127:0] v);
    for (int i = 0; i < 4; i++) wr(a, v[127-32*i -: 32]);
  endtask

  task automatic rdres(input string nm, input logic [127:0] e);
    logic [31:0] x;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      wb(0, R_RES + 8'(4*i), 32'h0, 4'hF, x);
      r[127-32*i -: 32] = x;
    end
    chk(nm, r, e);
  endtask

  task automatic poll(input string nm, input logic [31:0] m);
    logic [31:0] x;
    int n;
    n = 0;
    do begin wb(0, R_CTRL, 32'h0, 4'hF, x); n++; end while ((x & m) != m && n < 40);
    chk(nm, 128'((x & m) == m), 128'(1));
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
  } vec_t;

  vec_t vt[16];
  logic [31:0] rx;
  int e0;

  initial begin
    vt[0]  = '{0, 8'h00, 32'h0,  4'hF, 32'h2};
    vt[1]  = '{0, 8'h30, 32'h0,  4'hF, 32'h0};
    vt[2]  = '{0, 8'h3C, 32'h0,  4'hF, 32'h0};
    vt[3]  = '{1, 8'h00, 32'h18, 4'h3, 32'h0};
    vt[4]  = '{0, 8'h00, 32'h0,  4'hF, 32'h2};
    vt[5]  = '{1, 8'h00, 32'h08, 4'hF, 32'h0};
    vt[6]  = '{0, 8'h00, 32'h0,  4'hF, 32'hA};
    vt[7]  = '{1, 8'h00, 32'h10, 4'hF, 32'h0};
    vt[8]  = '{0, 8'h00, 32'h0,  4'hF, 32'h12};
    vt[9]  = '{1, 8'h00, 32'h00, 4'hF, 32'h0};
    vt[10] = '{0, 8'h00, 32'h0,  4'hF, 32'h2};
    vt[11] = '{1, 8'h04, 32'h1,  4'hF, 32'h0};
    vt[12] = '{0, 8'h00, 32'h0,  4'hF, 32'h2};
    vt[13] = '{0, 8'h80, 32'h0,  4'hF, 32'h0};
    vt[14] = '{1, 8'h50, 32'hFFFF, 4'hF, 32'h0};
    vt[15] = '{0, 8'h50, 32'h0,  4'hF, 32'h0};

    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_blk_o", blk_o, 128'h0);
    chk("rst_pulses", 128'({enc_start, dec_start, key_expand, aes256}), 128'(0));

    // Register map, sel gating, unmapped space, ENC without key
    for (int i = 0; i < 16; i++) begin
      wb(vt[i].w, vt[i].a, vt[i].d, vt[i].s, rx);
      if (!vt[i].w) chk($sformatf("vec%0d", i), 128'(rx), 128'(vt[i].e));
    end
    chk("no_enc_without_key", 128'(n_enc), 128'(0));

    // FIPS-197 AES-128 encrypt then decrypt
    push4(R_KEYP, FK);
    wr(R_KEY, 32'h1);
    poll("keygen_ready", 32'h3);
    chk("key_o_128", key, {128'h0, FK});
    push4(R_DIN, PT);
    wr(R_ENC, 32'h1);
    chk("fips_blk_in", blk_o, PT);
    poll("fips_enc_done", 32'h4);
    rdres("fips_ct", CT);
    push4(R_DIN, CT);
    wr(R_DEC, 32'h1);
    poll("fips_dec_done", 32'h4);
    rdres("fips_pt", PT);
    rdchk("status_done", R_CTRL, 32'h7);

    // AES-256 key load
    wr(R_CTRL, 32'h10);
    push4(R_KEYP, 128'hA4A4A4A4_A5A5A5A5_A6A6A6A6_A7A7A7A7);
    wr(R_KEY, 32'h2);
    push4(R_KEYP, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
    chk("key_o_256", key, 256'hA4A4A4A4_A5A5A5A5_A6A6A6A6_A7A7A7A7_A0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
    chk("aes256_o", 128'(aes256), 128'(1));
    rdchk("status_256", R_CTRL, 32'h17);

    // CBC chaining with identity core
    wr(R_CTRL, 32'h08);
    push4(R_IV, {4{32'hFFFFFFFF}});
    push4(R_DIN, {4{32'h12345678}});
    wr(R_ENC, 32'h1);
    chk("cbc_enc_blk", blk_o, {4{32'hEDCBA987}});
    poll("cbc_enc_done", 32'h4);
    rdres("cbc_enc_res", {4{32'hEDCBA987}});
    push4(R_DIN, 128'h0);
    wr(R_ENC, 32'h1);
    chk("cbc_iv_chained", blk_o, {4{32'hEDCBA987}});
    poll("cbc_enc2_done", 32'h4);
    push4(R_DIN, {4{32'h11111111}});
    wr(R_DEC, 32'h1);
    chk("cbc_dec_blk", blk_o, {4{32'h11111111}});
    poll("cbc_dec_done", 32'h4);
    rdres("cbc_dec_res", {4{32'hFCDAB896}});
    push4(R_DIN, 128'h0);
    wr(R_ENC, 32'h1);
    chk("cbc_iv_from_din", blk_o, {4{32'h11111111}});
    poll("cbc_enc3_done", 32'h4);

    // Busy: commands and pushes during RUN are dropped
    wr(R_CTRL, 32'h0);
    core_lat = 20;
    push4(R_DIN, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    e0 = n_enc;
    wr(R_ENC, 32'h1);
    rdchk("status_busy", R_CTRL, 32'h1);
    wr(R_ENC, 32'h1);
    wr(R_DIN, 32'hDEADBEEF);
    wr(R_KEY, 32'h1);
    wr(R_CTRL, 32'h08);
    chk("busy_one_start", 128'(n_enc - e0), 128'(1));
    chk("busy_blk_held", blk_o, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    poll("busy_done", 32'h4);
    rdchk("busy_status_after", R_CTRL, 32'h7);
    rdres("busy_res", 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    wr(R_ENC, 32'h1);
    chk("busy_din_kept", blk_o, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    chk("busy_restart", 128'(n_enc - e0), 128'(2));

    // Reset in the middle of RUN
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #7 rst_n = 1;
    #1;
    chk("midrst_blk_o", blk_o, 128'h0);
    chk("midrst_key_o", key, 256'h0);
    e0 = n_enc;
    rdchk("midrst_status", R_CTRL, 32'h2);
    rdres("midrst_res", 128'h0);
    wr(R_ENC, 32'h1);
    repeat (25) @(posedge clk);
    #1;
    chk("midrst_no_start", 128'(n_enc - e0), 128'(0));
    rdchk("midrst_status2", R_CTRL, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
